// File: rtl/vga_timing_pkg.sv
// Shared constants, phase type and phase decode for the VGA raster timing block.
// Default constants describe 640x480@60 with an 800x525 total raster.
package vga_timing_pkg;

  localparam int unsigned HActiveDef = 640;
  localparam int unsigned HFpDef     = 16;
  localparam int unsigned HSyncDef   = 96;
  localparam int unsigned HBpDef     = 48;
  localparam int unsigned VActiveDef = 480;
  localparam int unsigned VFpDef     = 10;
  localparam int unsigned VSyncDef   = 2;
  localparam int unsigned VBpDef     = 33;

  localparam int unsigned HTotalDef = HActiveDef + HFpDef + HSyncDef + HBpDef;
  localparam int unsigned VTotalDef = VActiveDef + VFpDef + VSyncDef + VBpDef;

  localparam int unsigned HTotalMax = 2048;
  localparam int unsigned VTotalMax = 1024;

  localparam int unsigned HCW = 11;
  localparam int unsigned VCW = 10;

  typedef enum logic [1:0] {
    PH_ACT,
    PH_FP,
    PH_SYN,
    PH_BP
  } vga_phase_t;

  // Map a raster position on one axis to its phase.
  function automatic vga_phase_t phase_of(input int unsigned c,
                                          input int unsigned act,
                                          input int unsigned fp,
                                          input int unsigned syn);
    if (c < act) begin
      return PH_ACT;
    end else if (c < act + fp) begin
      return PH_FP;
    end else if (c < act + fp + syn) begin
      return PH_SYN;
    end else begin
      return PH_BP;
    end
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Raster timing bundle between the timing controller and its consumers.
// The controller uses the master modport; colour/board logic uses slave.
interface vga_timing_ctrl_if;
  import vga_timing_pkg::*;

  logic           pix_en;
  logic [HCW-1:0] hcount;
  logic [VCW-1:0] vcount;
  logic           hsync;
  logic           vsync;
  logic           active;
  logic           line_start;
  logic           frame_start;

  modport master (
    input  pix_en,
    output hcount,
    output vcount,
    output hsync,
    output vsync,
    output active,
    output line_start,
    output frame_start
  );

  modport slave (
    output pix_en,
    input  hcount,
    input  vcount,
    input  hsync,
    input  vsync,
    input  active,
    input  line_start,
    input  frame_start
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter, registered phase FSM and registered sync.
// Sync and phase are computed from the next count so they match the count presented.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned Active  = 640,
  parameter int unsigned Fp      = 16,
  parameter int unsigned Sync    = 96,
  parameter int unsigned Bp      = 48,
  parameter int unsigned Width   = 11,
  parameter bit          SyncPol = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [Width-1:0] count_o,
  output vga_phase_t       phase_o,
  output logic             sync_o,
  output logic             wrap_o
);

  localparam int unsigned      Total    = Active + Fp + Sync + Bp;
  localparam logic [Width-1:0] Last     = Width'(Total - 1);
  localparam vga_phase_t       PhaseRst = phase_of(Total - 1, Active, Fp, Sync);

  if (Total > (2 ** Width)) begin : g_width_chk
    $error("vga_axis_counter: total %0d does not fit in %0d bits", Total, Width);
  end

  logic [Width-1:0] count_q, count_d;
  vga_phase_t       phase_q, phase_d;
  logic             sync_q, sync_d;

  always_comb begin
    count_d = count_q;
    if (inc_i) begin
      count_d = (count_q == Last) ? '0 : count_q + Width'(1);
    end
    phase_d = phase_of(32'(count_d), Active, Fp, Sync);
    sync_d  = (phase_d == PH_SYN) ? SyncPol : ~SyncPol;
  end

  // Reset parks the axis on its last back-porch position so the first advance lands on 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= Last;
      phase_q <= PhaseRst;
      sync_q  <= ~SyncPol;
    end else begin
      count_q <= count_d;
      phase_q <= phase_d;
      sync_q  <= sync_d;
    end
  end

  assign count_o = count_q;
  assign phase_o = phase_q;
  assign sync_o  = sync_q;
  assign wrap_o  = (count_q == Last);

endmodule

// File: rtl/vga_timing_ctrl.sv
// VGA raster sequencer: hcount/vcount, hsync/vsync, active and start strobes.
// Define VGA_TIMING_ALIGN_EN to delay syncs/active one clk to line up with registered colour.
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = HActiveDef,
  parameter int unsigned H_FP     = HFpDef,
  parameter int unsigned H_SYNC   = HSyncDef,
  parameter int unsigned H_BP     = HBpDef,
  parameter int unsigned V_ACTIVE = VActiveDef,
  parameter int unsigned V_FP     = VFpDef,
  parameter int unsigned V_SYNC   = VSyncDef,
  parameter int unsigned V_BP     = VBpDef,
  parameter bit          SYNC_POL = 1'b0
) (
  input logic                clk,
  input logic                rst,
  vga_timing_ctrl_if.master  bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > HTotalMax) begin : g_h_chk
    $error("vga_timing_ctrl: H_TOTAL %0d exceeds %0d", H_TOTAL, HTotalMax);
  end
  if (V_TOTAL > VTotalMax) begin : g_v_chk
    $error("vga_timing_ctrl: V_TOTAL %0d exceeds %0d", V_TOTAL, VTotalMax);
  end

  logic [HCW-1:0] h_count;
  logic [VCW-1:0] v_count;
  vga_phase_t     h_phase, v_phase;
  logic           h_sync, v_sync;
  logic           h_wrap, v_wrap_unused;
  logic           v_inc;
  logic           active_raw;

  assign v_inc = bus.pix_en & h_wrap;

  vga_axis_counter #(
    .Active  (H_ACTIVE),
    .Fp      (H_FP),
    .Sync    (H_SYNC),
    .Bp      (H_BP),
    .Width   (HCW),
    .SyncPol (SYNC_POL)
  ) u_h_axis (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (bus.pix_en),
    .count_o (h_count),
    .phase_o (h_phase),
    .sync_o  (h_sync),
    .wrap_o  (h_wrap)
  );

  vga_axis_counter #(
    .Active  (V_ACTIVE),
    .Fp      (V_FP),
    .Sync    (V_SYNC),
    .Bp      (V_BP),
    .Width   (VCW),
    .SyncPol (SYNC_POL)
  ) u_v_axis (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (v_inc),
    .count_o (v_count),
    .phase_o (v_phase),
    .sync_o  (v_sync),
    .wrap_o  (v_wrap_unused)
  );

  assign active_raw = (h_phase == PH_ACT) && (v_phase == PH_ACT);

  assign bus.hcount      = h_count;
  assign bus.vcount      = v_count;
  assign bus.line_start  = bus.pix_en && (h_count == '0);
  assign bus.frame_start = bus.pix_en && (h_count == '0) && (v_count == '0);

`ifdef VGA_TIMING_ALIGN_EN
  logic hsync_q, vsync_q, active_q;

  // Free-running stage: tracks the colour pipeline, which registers every clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
      active_q <= 1'b0;
    end else begin
      hsync_q  <= h_sync;
      vsync_q  <= v_sync;
      active_q <= active_raw;
    end
  end

  assign bus.hsync  = hsync_q;
  assign bus.vsync  = vsync_q;
  assign bus.active = active_q;
`else
  assign bus.hsync  = h_sync;
  assign bus.vsync  = v_sync;
  assign bus.active = active_raw;
`endif

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl: a default 800x525 instance and a small 15x8 instance.
// Expectations shift by one clk on syncs/active when VGA_TIMING_ALIGN_EN is defined.
module tb_vga_timing_ctrl;

`ifdef VGA_TIMING_ALIGN_EN
  localparam int AL = 1;
`else
  localparam int AL = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  vga_timing_ctrl_if bus_d ();
  vga_timing_ctrl_if bus_s ();

  vga_timing_ctrl dut_d (
    .clk (clk),
    .rst (rst),
    .bus (bus_d)
  );

  // Small raster: H 8/2/3/2 (total 15), V 4/1/2/1 (total 8).
  vga_timing_ctrl #(
    .H_ACTIVE (8),
    .H_FP     (2),
    .H_SYNC   (3),
    .H_BP     (2),
    .V_ACTIVE (4),
    .V_FP     (1),
    .V_SYNC   (2),
    .V_BP     (1),
    .SYNC_POL (1'b0)
  ) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hs_first, hs_last, hs_cnt, act_low, act_cnt, ls_cnt, fs_cnt;
    int vs_min, vs_max, vs_cnt, seen_last;
    int prev_h, prev_act, prev_hs;
    bit found;

    bus_d.pix_en = 1'b1;
    bus_s.pix_en = 1'b1;
    #12;

    // Reset state, held while clocks run
    check("rst_hcount", bus_d.hcount, 799);
    check("rst_vcount", bus_d.vcount, 524);
    check("rst_hsync", bus_d.hsync, 1);
    check("rst_vsync", bus_d.vsync, 1);
    check("rst_active", bus_d.active, 0);
    check("rst_line_start", bus_d.line_start, 0);
    check("rst_frame_start", bus_d.frame_start, 0);
    check("rst_s_hcount", bus_s.hcount, 14);
    check("rst_s_vcount", bus_s.vcount, 7);

    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("first_hcount", bus_d.hcount, 0);
    check("first_vcount", bus_d.vcount, 0);
    check("first_active", bus_d.active, 1 - AL);
    check("first_line_start", bus_d.line_start, 1);
    check("first_frame_start", bus_d.frame_start, 1);
    check("first_hsync", bus_d.hsync, 1);

    // One full line on the default raster
    hs_first = -1; hs_last = -1; hs_cnt = 0; act_low = -1; act_cnt = 0;
    ls_cnt = 0; fs_cnt = 0;
    for (int i = 0; i < 800; i++) begin
      if (bus_d.hsync == 1'b0) begin
        if (hs_first < 0) hs_first = int'(bus_d.hcount);
        hs_last = int'(bus_d.hcount);
        hs_cnt++;
      end
      if (bus_d.active) act_cnt++;
      if (bus_d.hcount != 0 && !bus_d.active && act_low < 0) act_low = int'(bus_d.hcount);
      ls_cnt += int'(bus_d.line_start);
      fs_cnt += int'(bus_d.frame_start);
      tick();
    end
    check("hsync_first", hs_first, 656 + AL);
    check("hsync_last", hs_last, 751 + AL);
    check("hsync_width", hs_cnt, 96);
    check("active_fall", act_low, 640 + AL);
    check("active_count", act_cnt, 640);
    check("line_start_count", ls_cnt, 1);
    check("frame_start_count_line", fs_cnt, 1);
    check("line1_hcount", bus_d.hcount, 0);
    check("line1_vcount", bus_d.vcount, 1);
    check("line1_line_start", bus_d.line_start, 1);
    check("line1_frame_start", bus_d.frame_start, 0);

    // pix_en toggling: hold on 0, advance on 1
    for (int i = 0; i < 5; i++) tick();
    for (int k = 0; k < 10; k++) begin
      prev_h   = int'(bus_d.hcount);
      prev_act = int'(bus_d.active);
      prev_hs  = int'(bus_d.hsync);
      bus_d.pix_en = 1'b0;
      tick();
      check("hold_hcount", bus_d.hcount, prev_h);
      check("hold_active", bus_d.active, prev_act);
      check("hold_hsync", bus_d.hsync, prev_hs);
      check("hold_line_start", bus_d.line_start, 0);
      bus_d.pix_en = 1'b1;
      tick();
      check("adv_hcount", bus_d.hcount, prev_h + 1);
    end

    // Walk to hcount=300 on line 1, bounded
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (bus_d.hcount == 300) found = 1'b1;
      else tick();
    end
    check("reach_h300", found, 1);
    check("reach_v1", bus_d.vcount, 1);

    // Asynchronous reset mid-line
    #3 rst = 1'b1;
    #1;
    check("async_rst_hcount", bus_d.hcount, 799);
    check("async_rst_vcount", bus_d.vcount, 524);
    check("async_rst_hsync", bus_d.hsync, 1);
    check("async_rst_vsync", bus_d.vsync, 1);
    check("async_rst_active", bus_d.active, 0);
    tick();
    rst = 1'b0;
    tick();
    check("resume_hcount", bus_d.hcount, 0);
    check("resume_vcount", bus_d.vcount, 0);
    check("resume_frame_start", bus_d.frame_start, 1);

    // Start strobes gated by pix_en even at (0,0)
    bus_d.pix_en = 1'b0;
    #1;
    check("gated_line_start", bus_d.line_start, 0);
    check("gated_frame_start", bus_d.frame_start, 0);

    // Full frame on the small raster
    vs_min = -1; vs_max = -1; vs_cnt = 0; ls_cnt = 0; fs_cnt = 0; seen_last = 0;
    for (int i = 0; i < 120; i++) begin
      if (bus_s.vsync == 1'b0) begin
        if (vs_min < 0) vs_min = int'(bus_s.vcount);
        vs_max = int'(bus_s.vcount);
        vs_cnt++;
      end
      if (bus_s.hcount == 14 && bus_s.vcount == 7) seen_last++;
      ls_cnt += int'(bus_s.line_start);
      fs_cnt += int'(bus_s.frame_start);
      tick();
    end
    check("s_vsync_first_line", vs_min, 5);
    check("s_vsync_last_line", vs_max, 6 + AL);
    check("s_vsync_samples", vs_cnt, 30);
    check("s_line_start_count", ls_cnt, 8);
    check("s_frame_start_count", fs_cnt, 1);
    check("s_seen_last_pos", seen_last, 1);
    check("s_wrap_hcount", bus_s.hcount, 0);
    check("s_wrap_vcount", bus_s.vcount, 0);
    check("s_wrap_frame_start", bus_s.frame_start, 1);
    check("held_d_hcount", bus_d.hcount, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
